// File: rtl/btu_pkg.sv
// -----------------------------------------------------------------------------
// btu_pkg
// Shared types and constants for the branch target unit.
//   btu_op_e     : operation encoding carried on in_op
//   BTU_LINK_INC : byte distance from an instruction to its link address
//   btu_entry_t  : one result-queue entry (target, link, flags)
// Configuration macro: BTU_MISALIGN_CHECK_EN
//   When undefined the misaligned flag is not part of the queue entry.
// -----------------------------------------------------------------------------
package btu_pkg;

  typedef enum logic [1:0] {
    BTU_BRANCH = 2'b00,
    BTU_JAL    = 2'b01,
    BTU_JALR   = 2'b10,
    BTU_RSVD   = 2'b11
  } btu_op_e;

  localparam int BTU_LINK_INC = 4;

  // Widest supported address; narrower builds leave the upper bits at zero.
  localparam int BTU_XLEN_MAX = 64;

  typedef struct packed {
    logic [BTU_XLEN_MAX-1:0] target;
    logic [BTU_XLEN_MAX-1:0] link;
`ifdef BTU_MISALIGN_CHECK_EN
    logic                    misaligned;
`endif
    logic                    illegal;
  } btu_entry_t;

endpackage

// File: rtl/btu_fifo.sv
// -----------------------------------------------------------------------------
// btu_fifo
// Generic DEPTH-entry synchronous FIFO with a synchronous flush.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : clears occupancy and pointers at the next edge
//   wr_valid_i/wr_ready_o: push handshake, wr_data_i is the pushed word
//   rd_valid_o/rd_ready_i: pop handshake, rd_data_o is the head word
// rd_data_o is forced to zero while the queue is empty.
// -----------------------------------------------------------------------------
module btu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign rd_valid_o = (count_q != {CW{1'b0}});
  // A pop that coincides with a flush is discarded along with everything else.
  assign pop_s      = rd_valid_o && rd_ready_i && !flush_i;
  // A full queue still accepts when its head leaves in the same cycle.
  assign wr_ready_o = !flush_i && ((count_q < FULL_C) || (rd_valid_o && rd_ready_i));
  assign push_s     = wr_valid_i && wr_ready_o;
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// -----------------------------------------------------------------------------
// branch_target_unit
// Computes branch/JAL/JALR targets and link addresses and queues the results
// for the PC-select stage.
// Parameters: XLEN (32 or 64), DEPTH (power of two, >= 2).
// Ports:
//   clock, reset (async active-low), flush (sync queue clear)
//   in_valid/in_ready, in_op, in_pc, in_rs1, in_imm : request side
//   out_valid/out_ready, out_target, out_link,
//   out_misaligned, out_illegal                      : result side
// Configuration macro: BTU_MISALIGN_CHECK_EN
//   Defined  : out_misaligned reports target[1] for legal ops.
//   Undefined: out_misaligned is tied to 0.
// -----------------------------------------------------------------------------
module branch_target_unit
  import btu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_misaligned,
  output logic            out_illegal
);

  logic [XLEN-1:0] br_target_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] link_s;
  logic            illegal_s;
  btu_entry_t      wr_entry_s;
  btu_entry_t      rd_entry_s;

  // All sums wrap modulo 2^XLEN; the carry out is simply dropped.
  assign br_target_s = in_pc + (in_imm << 1);
  assign jalr_sum_s  = in_rs1 + in_imm;
  assign link_s      = in_pc + XLEN'(BTU_LINK_INC);

  // Select the target for the requested operation.
  always_comb begin
    target_s  = {XLEN{1'b0}};
    illegal_s = 1'b0;
    case (btu_op_e'(in_op))
      BTU_BRANCH, BTU_JAL: target_s  = br_target_s;
      BTU_JALR:            target_s  = {jalr_sum_s[XLEN-1:1], 1'b0};
      BTU_RSVD:            illegal_s = 1'b1;
      default:             illegal_s = 1'b1;
    endcase
  end

  // Pack the queue entry; bits above XLEN stay zero.
  always_comb begin
    wr_entry_s                    = '0;
    wr_entry_s.target[XLEN-1:0]   = target_s;
    wr_entry_s.link[XLEN-1:0]     = link_s;
`ifdef BTU_MISALIGN_CHECK_EN
    // Without the C extension any target with bit 1 set is misaligned.
    wr_entry_s.misaligned         = !illegal_s && target_s[1];
`endif
    wr_entry_s.illegal            = illegal_s;
  end

  btu_fifo #(
    .WIDTH ($bits(btu_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset),
    .flush_i    (flush),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  (wr_entry_s),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (rd_entry_s)
  );

  // The FIFO already zeroes its head while empty.
  assign out_target  = rd_entry_s.target[XLEN-1:0];
  assign out_link    = rd_entry_s.link[XLEN-1:0];
  assign out_illegal = rd_entry_s.illegal;
`ifdef BTU_MISALIGN_CHECK_EN
  assign out_misaligned = rd_entry_s.misaligned;
`else
  assign out_misaligned = 1'b0;
`endif

  // Upper address bits are constant zero in narrow builds.
  if (XLEN < BTU_XLEN_MAX) begin : g_narrow
    logic unused_hi_s;
    assign unused_hi_s = ^{rd_entry_s.target[BTU_XLEN_MAX-1:XLEN],
                           rd_entry_s.link[BTU_XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_target_unit
// Directed and randomized stimulus for branch_target_unit (XLEN 32, DEPTH 2),
// checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_branch_target_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_pc, in_rs1, in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_target, out_link;
  logic            out_misaligned, out_illegal;

  typedef struct {
    logic [XLEN-1:0] t;
    logic [XLEN-1:0] l;
    logic            m;
    logic            i;
  } exp_t;

  exp_t mq[$];
  int   errors = 0;
  int   checks = 0;
  logic rdy_seen;
  logic mis_exp;

  branch_target_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_imm         (in_imm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_target     (out_target),
    .out_link       (out_link),
    .out_misaligned (out_misaligned),
    .out_illegal    (out_illegal)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from the arithmetic rules, using wide unsigned math.
  function automatic exp_t model(input logic [1:0] op, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm);
    exp_t e;
    longint unsigned s;
    longint unsigned lp, lr, li;
    lp = pc; lr = rs1; li = imm;
    e.l = XLEN'((lp + 4) % MOD);
    e.i = 1'b0;
    e.m = 1'b0;
    if (op == 2'd0 || op == 2'd1) begin
      s = (lp + 2 * li) % MOD;
    end else if (op == 2'd2) begin
      s = (lr + li) % MOD;
      if (s % 2 == 1) s = s - 1;
    end else begin
      s = 0;
      e.i = 1'b1;
    end
    e.t = XLEN'(s);
`ifdef BTU_MISALIGN_CHECK_EN
    if (!e.i) e.m = ((s % 4) >= 2);
`endif
    return e;
  endfunction

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic v, input logic [1:0] op, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                      input logic ordy, input logic fl);
    logic exp_rdy;
    int   n;
    @(negedge clock);
    in_valid = v; in_op = op; in_pc = pc; in_rs1 = rs1; in_imm = imm;
    out_ready = ordy; flush = fl;
    #1;
    n = mq.size();
    exp_rdy = !fl && (n < DEPTH || (n > 0 && ordy));
    rdy_seen = in_ready;
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, n > 0);
    if (n > 0) begin
      check_eq("target", out_target, mq[0].t);
      check_eq("link", out_link, mq[0].l);
      check_eq("misaligned", out_misaligned, mq[0].m);
      check_eq("illegal", out_illegal, mq[0].i);
    end else begin
      check_eq("idle_data", {out_target, out_link, out_misaligned, out_illegal}, 64'd0);
    end
    @(posedge clock);
    if (fl) begin
      mq.delete();
    end else begin
      if (n > 0 && ordy) void'(mq.pop_front());
      if (v && exp_rdy) mq.push_back(model(op, pc, rs1, imm));
    end
  endtask

  initial begin
`ifdef BTU_MISALIGN_CHECK_EN
    mis_exp = 1'b1;
`else
    mis_exp = 1'b0;
`endif
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0;
    in_pc = '0; in_rs1 = '0; in_imm = '0; out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_data", {out_target, out_link, out_misaligned, out_illegal}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // BRANCH pc 0x100 imm 0x10
    step(1'b1, 2'd0, 32'h100, 32'h0, 32'h10, 1'b1, 1'b0);
    #1;
    check_eq("br_valid", out_valid, 1'b1);
    check_eq("br_target", out_target, 32'h120);
    check_eq("br_link", out_link, 32'h104);
    check_eq("br_mis", out_misaligned, 1'b0);

    // JALR variants
    step(1'b1, 2'd2, 32'h0, 32'h2001, 32'h4, 1'b1, 1'b0);
    #1;
    check_eq("jalr_target", out_target, 32'h2004);
    step(1'b1, 2'd2, 32'h0, 32'h2003, 32'h0, 1'b1, 1'b0);
    #1;
    check_eq("jalr_odd_target", out_target, 32'h2002);
    check_eq("jalr_odd_mis", out_misaligned, mis_exp);

    // JAL with wrap-around
    step(1'b1, 2'd1, 32'hFFFF_FFF0, 32'h0, 32'h10, 1'b1, 1'b0);
    #1;
    check_eq("jal_wrap_target", out_target, 32'h0000_0010);
    check_eq("jal_wrap_link", out_link, 32'hFFFF_FFF4);
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: fill, stall, then simultaneous pop and push
    step(1'b1, 2'd1, 32'h200, 32'h0, 32'h1, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'h300, 32'h0, 32'h2, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'h400, 32'h0, 32'h3, 1'b0, 1'b0);
    check_eq("full_stall", rdy_seen, 1'b0);
    step(1'b1, 2'd1, 32'h400, 32'h0, 32'h3, 1'b1, 1'b0);
    check_eq("full_pop_push", rdy_seen, 1'b1);
    #1;
    check_eq("order_second", out_target, 32'h304);
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("still_full", rdy_seen, 1'b0);

    // Flush with a concurrent request
    step(1'b1, 2'd0, 32'h500, 32'h0, 32'h1, 1'b1, 1'b1);
    check_eq("flush_ready", rdy_seen, 1'b0);
    #1;
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_data", {out_target, out_link}, 64'd0);

    // Reserved op
    step(1'b1, 2'd3, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check_eq("rsvd_illegal", out_illegal, 1'b1);
    check_eq("rsvd_target", out_target, 32'h0);
    check_eq("rsvd_link", out_link, 32'h44);

    // Reset with a full queue
    step(1'b1, 2'd1, 32'h600, 32'h0, 32'h8, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_ready", in_ready, 1'b1);
    check_eq("midrst_data", {out_target, out_link}, 64'd0);
    mq.delete();
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
